result_ram_writer: RTL
======================

// Module: result_ram_writer
// PURPOSE
//   Write-back end of the brightness pipeline; the counterpart of the RAM loader that
//   feeds the systolic array. Takes blocks of DEPTH normalized results (pe3x_norm_out),
//   saturates each lane to the RAM pixel width and writes the lanes sequentially into
//   the single-port pixel RAM, starting at a programmable base address.
// PARAMETERS
//   RAM_ADDR_WIDTH  6   RAM address width; the address space is 2**RAM_ADDR_WIDTH words
//   RAM_DATA_WIDTH  8   RAM word width (one pixel)
//   PE_DATA_WIDTH   16  width of each normalized result lane
//   DEPTH           4   lanes per result block (array row width)
// PORTS
//   clk           in   1                      system clock, rising edge
//   reset         in   1                      asynchronous, active-low reset
//   start         in   1                      one-cycle pulse; sampled only in IDLE
//   base_addr     in   RAM_ADDR_WIDTH         first write address, latched on start
//   num_blocks    in   RAM_ADDR_WIDTH         number of result blocks to write, latched on start
//   result_valid  in   1                      result block present on result_data
//   result_data   in   PE_DATA_WIDTH*DEPTH    lane i = bits[i*PE_DATA_WIDTH +: PE_DATA_WIDTH]
//   result_ready  out  1                      writer can accept a block
//   ram_we        out  1                      RAM write enable
//   ram_addr      out  RAM_ADDR_WIDTH         RAM write address
//   ram_wdata     out  RAM_DATA_WIDTH         RAM write data
//   busy          out  1                      high in every state except IDLE
//   done          out  1                      one-cycle pulse at the end of a job
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; all outputs 0; address, lane and block counters 0.
//   FSM states: IDLE, WAIT_RESULT, WRITE, FINISH, DONE.
//   - IDLE: on start=1, latch base_addr into addr_ptr and latch num_blocks, and clear blk_cnt.
//     If num_blocks==0, go to FINISH; otherwise go to WAIT_RESULT. Start is ignored in other states.
//   - WAIT_RESULT: result_ready=1. When result_valid&&result_ready, capture result_data into
//     a DEPTH-lane buffer, set lane=0 and go to WRITE. result_ready drops the next cycle.
//   - WRITE: result_ready=0. Each cycle, drive ram_we=1, ram_addr=addr_ptr and
//     ram_wdata=sat(lane[lane]); then increment addr_ptr and lane. Lane 0 is written first.
//     After lane DEPTH-1: increment blk_cnt. If blk_cnt+1==num_blocks go to FINISH,
//     otherwise go to WAIT_RESULT.
//   - FINISH: ram_we=0 for one cycle, which gives the RAM its write-settle slot. Then go to DONE.
//   - DONE: done=1 for exactly one cycle, then go to IDLE. busy=0 from IDLE onward.
//   Outputs ram_we, ram_addr and ram_wdata are registered. ram_we is 0 in every state except WRITE.
//   Latency: the first RAM write occurs 1 cycle after the accepting handshake. A block occupies
//   exactly DEPTH write cycles. Minimum spacing between accepted blocks is DEPTH+1 cycles.
//   sat(x): unsigned; if x > 2**RAM_DATA_WIDTH-1, output all ones; otherwise output x[RAM_DATA_WIDTH-1:0].
//   Address wrap: addr_ptr increments modulo 2**RAM_ADDR_WIDTH (63 -> 0), with no error flag.
//   Input changes on result_data while in WRITE have no effect, because the buffer is captured once.
//   start together with result_valid in IDLE: start is taken. result_valid is not accepted
//   until WAIT_RESULT.
//   Reset mid-job: the job is aborted immediately; ram_we=0 asynchronously. No done pulse.
//   A new start is required after reset.
// TESTING
//   1. Reset, then start(base=0, n=1), one block lanes {0x0010,0x0020,0x0030,0x0040} ->
//      writes 0x10@0, 0x20@1, 0x30@2, 0x40@3 on consecutive cycles; done pulses once 2 cycles later.
//   2. Saturation: lanes {0x00FF,0x0100,0xFFFF,0x0000} -> wdata 0xFF,0xFF,0xFF,0x00.
//   3. Wrap: base=62, n=1 -> addresses 62,63,0,1 in order.
//   4. Backpressure: n=3, result_valid held high continuously -> exactly 12 writes to
//      addr 0..11; result_ready low during every WRITE cycle.
//   5. num_blocks=0 -> no ram_we ever asserted; done pulses 2 cycles after start.
//   6. Reset asserted during the 2nd lane of a block -> ram_we=0 at once; busy=0; no done;
//      a fresh start(base=8, n=1) then writes correctly from addr 8.

Source files
------------

// File: rtl/result_ram_writer.sv
// result_ram_writer: saturates DEPTH-lane result blocks to pixel width and writes them sequentially into the pixel RAM
module result_ram_writer #(
    parameter int RAM_ADDR_WIDTH = 6,
    parameter int RAM_DATA_WIDTH = 8,
    parameter int PE_DATA_WIDTH  = 16,
    parameter int DEPTH          = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [RAM_ADDR_WIDTH-1:0]         base_addr,
    input  logic [RAM_ADDR_WIDTH-1:0]         num_blocks,
    input  logic                              result_valid,
    input  logic [PE_DATA_WIDTH*DEPTH-1:0]    result_data,
    output logic                              result_ready,
    output logic                              ram_we,
    output logic [RAM_ADDR_WIDTH-1:0]         ram_addr,
    output logic [RAM_DATA_WIDTH-1:0]         ram_wdata,
    output logic                              busy,
    output logic                              done
);
    localparam int LW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] LAST = LW'(DEPTH - 1);
    localparam logic [LW-1:0] LONE = LW'(1);
    localparam logic [RAM_ADDR_WIDTH-1:0] AONE = RAM_ADDR_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, WAIT_RESULT, WRITE, FINISH, DONE} state_t;

    state_t                            state, state_n;
    logic [RAM_ADDR_WIDTH-1:0]         addr_ptr, nb, blk_cnt;
    logic [LW-1:0]                     lane, lane_n;
    logic [PE_DATA_WIDTH*DEPTH-1:0]    blk_buf;
    logic [PE_DATA_WIDTH-1:0]          nxt_pix;
    logic                              accept, lane_last, last_blk;

    function automatic logic [RAM_DATA_WIDTH-1:0] sat(input logic [PE_DATA_WIDTH-1:0] x);
        return |(x >> RAM_DATA_WIDTH) ? '1 : x[RAM_DATA_WIDTH-1:0];
    endfunction

    // lane holds the index of the lane currently on the RAM bus
    always_comb begin
        accept    = state == WAIT_RESULT && result_valid;
        lane_last = lane == LAST;
        last_blk  = blk_cnt + AONE == nb;
        lane_n    = lane + LONE;
        nxt_pix   = accept ? result_data[0 +: PE_DATA_WIDTH] : blk_buf[lane_n*PE_DATA_WIDTH +: PE_DATA_WIDTH];
        state_n   = state;
        case (state)
            IDLE:        state_n = start ? (num_blocks == '0 ? FINISH : WAIT_RESULT) : IDLE;
            WAIT_RESULT: state_n = result_valid ? WRITE : WAIT_RESULT;
            WRITE:       state_n = lane_last ? (last_blk ? FINISH : WAIT_RESULT) : WRITE;
            FINISH:      state_n = DONE;
            default:     state_n = IDLE;
        endcase
    end

    assign result_ready = state == WAIT_RESULT;
    assign busy         = state != IDLE;
    assign done         = state == DONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_ptr  <= '0;
            nb        <= '0;
            blk_cnt   <= '0;
            lane      <= '0;
            blk_buf   <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state  <= state_n;
            ram_we <= 1'b0;
            if (state == IDLE && start) begin
                addr_ptr <= base_addr;
                nb       <= num_blocks;
                blk_cnt  <= '0;
            end
            if (accept) begin
                blk_buf <= result_data;
                lane    <= '0;
            end
            if (state == WRITE) begin
                lane <= lane_n;
                if (lane_last)
                    blk_cnt <= blk_cnt + AONE;
            end
            // the accept edge already issues lane 0, so the block spans exactly DEPTH WRITE cycles
            if (accept || (state == WRITE && !lane_last)) begin
                ram_we    <= 1'b1;
                ram_addr  <= addr_ptr;
                ram_wdata <= sat(nxt_pix);
                addr_ptr  <= addr_ptr + AONE;
            end
        end
    end
endmodule
